debounce_bank: RTL and testbench

Parametrised multi-channel debouncer for the board's push-buttons and slide switches. It replaces the per-pin single-channel debouncers with one bank that synchronises N raw inputs and filters them with a stable-time counter per channel. Each channel produces a clean level, single-cycle press and release pulses, and a long-press pulse. Downstream FSMs (menu, game control) consume the pulses directly and need no edge detection of their own.

---
 rtl/debounce_bank.sv | 168 ++++++++++++++++
 tb/tb_debounce_bank.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// N-channel push-button debouncer: 2-flop synchroniser, stable-time filter and press/release/long-press FSM per channel.
// Define DEBOUNCE_REPEAT_EN to build the auto-repeat counter that drives rpt after a long press.
module debounce_bank #(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = 500000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] rel,
    output logic [N-1:0] hold,
    output logic [N-1:0] rpt
);

    localparam int CW   = $clog2(STABLE_CYCLES + 1);
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            logic          s1_reg;
            logic          s2_reg;
            logic          level_reg;
            logic [CW-1:0] cnt_reg;
            logic          upd;
            logic          rise_upd;
            logic          fall_upd;
            state_t        state_reg;
            state_t        state_next;
            logic [HW-1:0] hcnt_reg;
            logic [HW-1:0] hcnt_next;
            logic          press_reg;
            logic          press_next;
            logic          rel_reg;
            logic          rel_next;
            logic          hold_reg;
            logic          hold_next;

            // Level only flips after sync has disagreed with it for STABLE_CYCLES consecutive cycles.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_reg    <= 1'b0;
                    s2_reg    <= 1'b0;
                    level_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    s1_reg <= in[gi] ^ ACTIVE_LOW;
                    s2_reg <= s1_reg;
                    if (s2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CW'(STABLE_CYCLES - 1)) begin
                        level_reg <= s2_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign upd      = (s2_reg != level_reg) && (cnt_reg == CW'(STABLE_CYCLES - 1));
            assign rise_upd = upd & s2_reg;
            assign fall_upd = upd & ~s2_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= IDLE;
                    hcnt_reg  <= '0;
                    press_reg <= 1'b0;
                    rel_reg   <= 1'b0;
                    hold_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    hcnt_reg  <= hcnt_next;
                    press_reg <= press_next;
                    rel_reg   <= rel_next;
                    hold_reg  <= hold_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                hcnt_next  = hcnt_reg;
                case (state_reg)
                    IDLE: begin
                        if (rise_upd) begin
                            state_next = PRESSED;
                            hcnt_next  = '0;
                        end
                    end
                    PRESSED: begin
                        if (fall_upd) begin
                            state_next = IDLE;
                        end else if (hcnt_reg == HW'(HOLD_CYCLES - 1)) begin
                            state_next = HELD;
                            hcnt_next  = '0;
                        end else begin
                            hcnt_next = hcnt_reg + 1'b1;
                        end
                    end
                    HELD: begin
                        if (fall_upd) begin
                            state_next = IDLE;
`ifdef DEBOUNCE_REPEAT_EN
                        end else if (hcnt_reg == HW'(REPEAT_CYCLES - 1)) begin
                            hcnt_next = '0;
                        end else begin
                            hcnt_next = hcnt_reg + 1'b1;
`else
                        end else begin
                            hcnt_next = '0;
`endif
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        hcnt_next  = '0;
                    end
                endcase
            end

            // A falling update wins over a coinciding hold/repeat terminal count.
            always_comb begin
                press_next = (state_reg == IDLE) && rise_upd;
                rel_next   = (state_reg != IDLE) && fall_upd;
                hold_next  = (state_reg == PRESSED) && !fall_upd &&
                             (hcnt_reg == HW'(HOLD_CYCLES - 1));
            end

`ifdef DEBOUNCE_REPEAT_EN
            logic rpt_reg;
            logic rpt_next;

            assign rpt_next = (state_reg == HELD) && !fall_upd &&
                              (hcnt_reg == HW'(REPEAT_CYCLES - 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rpt_reg <= 1'b0;
                end else begin
                    rpt_reg <= rpt_next;
                end
            end

            assign rpt[gi] = rpt_reg;
`else
            assign rpt[gi] = 1'b0;
`endif

            assign level[gi] = level_reg;
            assign press[gi] = press_reg;
            assign rel[gi]   = rel_reg;
            assign hold[gi]  = hold_reg;
        end
    endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: N=2, STABLE=4, HOLD=10, REPEAT=3; edge k is the k-th edge sampling the new input.
module tb_debounce_bank;

    localparam int N  = 2;
    localparam int SC = 4;
    localparam int HC = 10;
    localparam int RC = 3;
`ifdef DEBOUNCE_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] in_v = '0;
    logic [N-1:0] level, press, rel, hold, rpt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    debounce_bank #(
        .N(N), .STABLE_CYCLES(SC), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in_v),
        .level(level), .press(press), .rel(rel), .hold(hold), .rpt(rpt)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        in_v  = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [9:0] got;
        rst_n = 1'b0;
        in_v  = '0;
        #1;
        got = {level, press, rel, hold, rpt};
        n_cmp++;
        if (got !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_async: got %b expected %b", got, 10'b0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        got = {level, press, rel, hold, rpt};
        n_cmp++;
        if (got !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_release: got %b expected %b", got, 10'b0);
        end
    endtask

    task automatic test_press_hold_repeat;
        logic [9:0] got, exp;
        logic [1:0] e_l, e_p, e_r, e_h, e_t;
        do_reset();
        for (int k = 1; k <= 45; k++) begin
            in_v = (k <= 30) ? 2'b01 : 2'b00;
            tick();
            e_l = {1'b0, (k >= 6 && k <= 35)};
            e_p = {1'b0, (k == 6)};
            e_r = {1'b0, (k == 36)};
            e_h = {1'b0, (k == 16)};
            e_t = {1'b0, REP_EN && (k inside {19, 22, 25, 28, 31, 34})};
            exp = {e_l, e_p, e_r, e_h, e_t};
            got = {level, press, rel, hold, rpt};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL press_hold_repeat edge %0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_glitch;
        logic [9:0] got;
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            in_v    = '0;
            in_v[0] = (k inside {1, 2, 3, 5, 6, 7});
            tick();
            got = {level, press, rel, hold, rpt};
            n_cmp++;
            if (got !== 10'b0) begin
                n_bad++;
                $display("FAIL glitch edge %0d: got %b expected %b", k, got, 10'b0);
            end
        end
    endtask

    task automatic test_low_glitch;
        logic [9:0] got, exp;
        logic [1:0] e_l, e_p, e_h, e_t;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            in_v    = '0;
            in_v[0] = !(k inside {11, 12});
            tick();
            e_l = {1'b0, (k >= 6)};
            e_p = {1'b0, (k == 6)};
            e_h = {1'b0, (k == 16)};
            e_t = {1'b0, REP_EN && (k == 19)};
            exp = {e_l, e_p, 2'b00, e_h, e_t};
            got = {level, press, rel, hold, rpt};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL low_glitch edge %0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_release_at_hold;
        logic [9:0] got, exp;
        logic [1:0] e_l, e_p, e_r;
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            in_v = (k <= 10) ? 2'b01 : 2'b00;
            tick();
            e_l = {1'b0, (k >= 6 && k <= 15)};
            e_p = {1'b0, (k == 6)};
            e_r = {1'b0, (k == 16)};
            exp = {e_l, e_p, e_r, 2'b00, 2'b00};
            got = {level, press, rel, hold, rpt};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL release_at_hold edge %0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_two_channels;
        logic [9:0] got, exp;
        logic [1:0] e_l, e_p, e_r, e_h, e_t;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            in_v[0] = 1'b1;
            in_v[1] = (k <= 8);
            tick();
            e_l = {(k >= 6 && k <= 13), (k >= 6)};
            e_p = {(k == 6), (k == 6)};
            e_r = {(k == 14), 1'b0};
            e_h = {1'b0, (k == 16)};
            e_t = {1'b0, REP_EN && (k == 19)};
            exp = {e_l, e_p, e_r, e_h, e_t};
            got = {level, press, rel, hold, rpt};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL two_channels edge %0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_reset_in_held;
        logic [9:0] got, exp;
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            in_v = 2'b01;
            tick();
        end
        got = {level, press, rel, hold, rpt};
        exp = {2'b01, 8'b0};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL held_before_reset: got %b expected %b", got, exp);
        end
        #1;
        rst_n = 1'b0;
        #1;
        got = {level, press, rel, hold, rpt};
        n_cmp++;
        if (got !== 10'b0) begin
            n_bad++;
            $display("FAIL held_reset_async: got %b expected %b", got, 10'b0);
        end
        for (int k = 1; k <= 2; k++) begin
            tick();
            got = {level, press, rel, hold, rpt};
            n_cmp++;
            if (got !== 10'b0) begin
                n_bad++;
                $display("FAIL held_reset_hold cycle %0d: got %b expected %b", k, got, 10'b0);
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_v = 2'b01;
            tick();
            exp = {1'b0, (k >= 6), 1'b0, (k == 6), 6'b0};
            got = {level, press, rel, hold, rpt};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL after_reset_press edge %0d: got %b expected %b", k, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_hold_repeat();
        test_glitch();
        test_low_glitch();
        test_release_at_hold();
        test_two_channels();
        test_reset_in_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
